// File: rtl/nnrv_ram_arb.sv
// nnrv_ram_arb: shares one single-port synchronous RAM between the
// instruction-fetch port and the data port. Data has fixed priority.
// Ifetch is forced through after STARVE_MAX consecutive denied cycles.
// Read data returns one cycle after the grant, routed to the requester
// that owned that access.
module nnrv_ram_arb #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_req,
    input  logic [XLEN-1:0] i_if_addr,
    output logic            o_if_gnt,
    output logic            o_if_rvalid,
    output logic [XLEN-1:0] o_if_rdata,
    input  logic            i_d_req,
    input  logic            i_d_we,
    input  logic [XLEN-1:0] i_d_addr,
    input  logic [XLEN-1:0] i_d_wdata,
    input  logic [3:0]      i_d_mask,
    output logic            o_d_gnt,
    output logic            o_d_rvalid,
    output logic [XLEN-1:0] o_d_rdata,
    output logic            o_ram_en,
    output logic            o_ram_we,
    output logic [XLEN-1:0] o_ram_addr,
    output logic [3:0]      o_ram_mask,
    output logic [XLEN-1:0] o_ram_wdata,
    input  logic [XLEN-1:0] i_ram_rdata
);

    // Owner of the RAM access issued in the previous cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        D_RD  = 2'd2,
        D_WR  = 2'd3
    } own_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    own_t       state;
    own_t       state_next;
    logic [3:0] starve_cnt;
    logic       force_if;

    // Grant decision: data wins unless ifetch has been starved long enough.
    always_comb begin
        force_if = (starve_cnt >= STARVE_LIM) && i_if_req;
        o_if_gnt = i_if_req && (!i_d_req || force_if);
        o_d_gnt  = i_d_req && !o_if_gnt;
    end

    // Steer the granted requester onto the RAM port; idle bus is all zeros.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned, which would infer a latch.
        o_ram_en    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_mask  = 4'h0;
        o_ram_wdata = '0;
        if (o_d_gnt) begin
            o_ram_en    = 1'b1;
            o_ram_we    = i_d_we;
            o_ram_addr  = i_d_addr;
            o_ram_mask  = i_d_mask;
            o_ram_wdata = i_d_wdata;
        end else if (o_if_gnt) begin
            o_ram_en    = 1'b1;
            o_ram_addr  = i_if_addr;
            o_ram_mask  = 4'hF;
        end
    end

    // Decode which access this cycle's grant starts.
    always_comb begin
        state_next = IDLE;
        if (o_if_gnt)
            state_next = IF_RD;
        else if (o_d_gnt)
            state_next = i_d_we ? D_WR : D_RD;
    end

    // Ownership FSM with registered rvalids; reset drops any access in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_if_rvalid <= 1'b0;
            o_d_rvalid  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            state       <= state_next;
            o_if_rvalid <= (state_next == IF_RD);
            o_d_rvalid  <= (state_next == D_RD);
        end
    end

    // Starvation counter: counts denied ifetch cycles, saturates at 15,
    // clears on an ifetch grant and holds while ifetch is not requesting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            starve_cnt <= 4'd0;
        else if (o_if_gnt)
            starve_cnt <= 4'd0;
        else if (i_if_req && starve_cnt != 4'hF)
            starve_cnt <= starve_cnt + 4'd1;
    end

    // RAM data arrives the cycle after the grant; route it to its owner only.
    always_comb begin
        o_if_rdata = (state == IF_RD) ? i_ram_rdata : '0;
        o_d_rdata  = (state == D_RD)  ? i_ram_rdata : '0;
    end

endmodule

// File: tb/tb_nnrv_ram_arb.sv
// tb_nnrv_ram_arb: scoreboard bench for nnrv_ram_arb. A small arbitration
// model predicts grants and RAM bus values; the owner of each cycle's
// access is queued and popped the next cycle to check the read return.
module tb_nnrv_ram_arb;

    localparam int XLEN = 32;

    logic            i_clk;
    logic            i_rst_n;
    logic            i_if_req;
    logic [XLEN-1:0] i_if_addr;
    logic            o_if_gnt;
    logic            o_if_rvalid;
    logic [XLEN-1:0] o_if_rdata;
    logic            i_d_req;
    logic            i_d_we;
    logic [XLEN-1:0] i_d_addr;
    logic [XLEN-1:0] i_d_wdata;
    logic [3:0]      i_d_mask;
    logic            o_d_gnt;
    logic            o_d_rvalid;
    logic [XLEN-1:0] o_d_rdata;
    logic            o_ram_en;
    logic            o_ram_we;
    logic [XLEN-1:0] o_ram_addr;
    logic [3:0]      o_ram_mask;
    logic [XLEN-1:0] o_ram_wdata;
    logic [XLEN-1:0] i_ram_rdata;

    nnrv_ram_arb #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_gnt    (o_if_gnt),
        .o_if_rvalid (o_if_rvalid),
        .o_if_rdata  (o_if_rdata),
        .i_d_req     (i_d_req),
        .i_d_we      (i_d_we),
        .i_d_addr    (i_d_addr),
        .i_d_wdata   (i_d_wdata),
        .i_d_mask    (i_d_mask),
        .o_d_gnt     (o_d_gnt),
        .o_d_rvalid  (o_d_rvalid),
        .o_d_rdata   (o_d_rdata),
        .o_ram_en    (o_ram_en),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_mask  (o_ram_mask),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} own_e;

    own_e sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle(input logic if_req, input logic [31:0] if_addr,
                         input logic d_req, input logic d_we, input logic [31:0] d_addr,
                         input logic [31:0] d_wdata, input logic [3:0] d_mask,
                         input logic [31:0] ram_rdata);
        own_e        prev;
        logic        frc, ig, dg;
        logic [69:0] bus_exp;
        i_if_req    = if_req;
        i_if_addr   = if_addr;
        i_d_req     = d_req;
        i_d_we      = d_we;
        i_d_addr    = d_addr;
        i_d_wdata   = d_wdata;
        i_d_mask    = d_mask;
        i_ram_rdata = ram_rdata;
        #1;
        prev = (sb.size() > 0) ? sb.pop_front() : OWN_NONE;
        check("if_rvalid", 128'(o_if_rvalid), 128'(prev == OWN_IF));
        check("if_rdata",  128'(o_if_rdata),  (prev == OWN_IF) ? 128'(ram_rdata) : 128'(0));
        check("d_rvalid",  128'(o_d_rvalid),  128'(prev == OWN_D));
        check("d_rdata",   128'(o_d_rdata),   (prev == OWN_D) ? 128'(ram_rdata) : 128'(0));
        check("starve_cnt", 128'(dut.starve_cnt), 128'(m_cnt));
        frc = (m_cnt >= 4) && if_req;
        ig  = if_req && (!d_req || frc);
        dg  = d_req && !ig;
        if (dg)      bus_exp = {1'b1, d_we, d_addr, d_mask, d_wdata};
        else if (ig) bus_exp = {1'b1, 1'b0, if_addr, 4'hF, 32'h0};
        else         bus_exp = '0;
        check("if_gnt", 128'(o_if_gnt), 128'(ig));
        check("d_gnt",  128'(o_d_gnt),  128'(dg));
        check("ram_bus", 128'({o_ram_en, o_ram_we, o_ram_addr, o_ram_mask, o_ram_wdata}), 128'(bus_exp));
        @(posedge i_clk);
        if (ig)          m_cnt = 0;
        else if (if_req) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        if (ig)               sb.push_back(OWN_IF);
        else if (dg && !d_we) sb.push_back(OWN_D);
        else                  sb.push_back(OWN_NONE);
        @(negedge i_clk);
    endtask

    task automatic idle(input logic [31:0] ram_rdata);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, ram_rdata);
    endtask

    task automatic contend(input logic [31:0] ram_rdata);
        cycle(1'b1, 32'h0000_0400, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF, ram_rdata);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_if_req    = 1'b0;
        i_if_addr   = '0;
        i_d_req     = 1'b0;
        i_d_we      = 1'b0;
        i_d_addr    = '0;
        i_d_wdata   = '0;
        i_d_mask    = '0;
        i_ram_rdata = 32'h5555_AAAA;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        check("rst_if_rvalid", 128'(o_if_rvalid), 128'(0));
        check("rst_d_rvalid",  128'(o_d_rvalid),  128'(0));
        check("rst_if_rdata",  128'(o_if_rdata),  128'(0));
        check("rst_d_rdata",   128'(o_d_rdata),   128'(0));
        check("rst_state",     128'(dut.state),   128'(0));
        check("rst_cnt",       128'(dut.starve_cnt), 128'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Ifetch only: three grants, returns A0, A1, A2 back to back.
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hA0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hA1);
        idle(32'hA2);

        // Data write then read at the same address.
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'b0011, 32'h1234_5678);
        idle(32'h0000_BEEF);

        // Continuous contention: period-5 pattern, data x4 then forced ifetch.
        for (int i = 0; i < 11; i++) contend($urandom);
        idle($urandom);

        // Alternating owners on consecutive cycles.
        cycle(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h700, 32'h0, 4'b1100, 32'hC0DE_0001);
        cycle(1'b1, 32'h604, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hC0DE_0002);
        idle(32'hC0DE_0003);

        // Build a nonzero counter, then reset in the grant cycle of a data read.
        contend($urandom);
        contend($urandom);
        i_if_req    = 1'b0;
        i_d_req     = 1'b1;
        i_d_we      = 1'b0;
        i_d_addr    = 32'h300;
        i_d_mask    = 4'hF;
        i_ram_rdata = 32'hBAD0_0000;
        #1;
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_d_req     = 1'b0;
        i_ram_rdata = 32'hBAD0_0001;
        i_rst_n     = 1'b1;
        sb.delete();
        m_cnt = 0;
        #1;
        check("mid_rst_d_rvalid", 128'(o_d_rvalid), 128'(0));
        check("mid_rst_state",    128'(dut.state),  128'(0));
        check("mid_rst_cnt",      128'(dut.starve_cnt), 128'(0));
        @(negedge i_clk);
        idle(32'hBAD0_0002);

        // After reset the counter starts at zero: four denials before ifetch wins.
        for (int i = 0; i < 5; i++) contend($urandom);
        contend($urandom);
        contend($urandom);

        // Idle: bus quiet, no rvalids, counter holds its value.
        for (int i = 0; i < 3; i++) idle($urandom);
        check("idle_cnt_hold", 128'(dut.starve_cnt), 128'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
